instr_decode_queue: RTL and testbench



---
 rtl/instr_decode_queue.sv | 115 +++++++++++
 tb/tb_instr_decode_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_queue.sv
// Decode front end: classifies LEGv8 opcodes for the sign-extend stage and
// buffers decoded entries in a 2-deep FIFO with a saturating illegal counter.
module instr_decode_queue (
    input  logic        Clk,
    input  logic        ResetL,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InInstr,
    input  logic [63:0] InPC,
    input  logic        Flush,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [25:0] OutImm26,
    output logic [2:0]  OutSignOp,
    output logic        OutImmUsed,
    output logic        OutIllegal,
    output logic [63:0] OutPC,
    output logic [7:0]  IllegalCount
);

    typedef struct packed {
        logic [25:0] imm26;
        logic [2:0]  sign_op;
        logic        imm_used;
        logic        illegal;
        logic [63:0] pc;
    } entry_t;

    entry_t     mem [2];
    entry_t     dec;
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // First matching opcode pattern wins; unmatched words are illegal.
    always_comb begin
        dec          = '0;
        dec.imm26    = InInstr[25:0];
        dec.pc       = InPC;
        if (InInstr[31:26] == 6'b000101) begin
            dec.sign_op  = 3'b010;
            dec.imm_used = 1'b1;
        end else if (InInstr[31:25] == 7'b1011010) begin
            dec.sign_op  = 3'b011;
            dec.imm_used = 1'b1;
        end else if (InInstr[31:21] == 11'b11111000010 ||
                     InInstr[31:21] == 11'b11111000000) begin
            dec.sign_op  = 3'b001;
            dec.imm_used = 1'b1;
        end else if (InInstr[31:22] == 10'b1001000100 ||
                     InInstr[31:22] == 10'b1101000100) begin
            dec.sign_op  = 3'b000;
            dec.imm_used = 1'b1;
        end else if (InInstr[31:23] == 9'b110100101) begin
            dec.sign_op  = 3'b100;
            dec.imm_used = 1'b1;
        end else if (InInstr[31:21] == 11'b10001011000 ||
                     InInstr[31:21] == 11'b11001011000 ||
                     InInstr[31:21] == 11'b10001010000 ||
                     InInstr[31:21] == 11'b10101010000) begin
            dec.sign_op  = 3'b000;
            dec.imm_used = 1'b0;
        end else begin
            dec.illegal  = 1'b1;
        end
    end

    assign InReady  = (count != 2'd2);
    assign OutValid = (count != 2'd0);
    assign push     = InValid & InReady & ~Flush;
    assign pop      = OutValid & OutReady & ~Flush;

    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            count        <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            IllegalCount <= '0;
            mem[0]       <= '0;
            mem[1]       <= '0;
        end else begin
            if (push && dec.illegal && IllegalCount != 8'hFF)
                IllegalCount <= IllegalCount + 8'd1;
            if (Flush) begin
                count  <= '0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= dec;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entries are zeroed on reset so the head reads as all-zero afterwards.
    assign head       = mem[rd_ptr];
    assign OutImm26   = head.imm26;
    assign OutSignOp  = head.sign_op;
    assign OutImmUsed = head.imm_used;
    assign OutIllegal = head.illegal;
    assign OutPC      = head.pc;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: a reference decoder feeds an
// expected-entry queue that is compared against the head every cycle.
module tb_instr_decode_queue;

    logic        Clk;
    logic        ResetL;
    logic        InValid;
    logic        InReady;
    logic [31:0] InInstr;
    logic [63:0] InPC;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [25:0] OutImm26;
    logic [2:0]  OutSignOp;
    logic        OutImmUsed;
    logic        OutIllegal;
    logic [63:0] OutPC;
    logic [7:0]  IllegalCount;

    typedef struct packed {
        logic [25:0] imm26;
        logic [2:0]  sign_op;
        logic        imm_used;
        logic        illegal;
        logic [63:0] pc;
    } exp_t;

    exp_t     sb [$];
    logic [7:0] m_ill;
    int       n_checks;
    int       n_errors;
    logic     last_push;

    instr_decode_queue dut (
        .Clk          (Clk),
        .ResetL       (ResetL),
        .InValid      (InValid),
        .InReady      (InReady),
        .InInstr      (InInstr),
        .InPC         (InPC),
        .Flush        (Flush),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutImm26     (OutImm26),
        .OutSignOp    (OutSignOp),
        .OutImmUsed   (OutImmUsed),
        .OutIllegal   (OutIllegal),
        .OutPC        (OutPC),
        .IllegalCount (IllegalCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Mask/compare view of the opcode table.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
        exp_t e;
        logic [31:0] m11;
        m11        = w & 32'hFFE0_0000;
        e          = '0;
        e.imm26    = w[25:0];
        e.pc       = pc;
        if ((w & 32'hFC00_0000) == 32'h1400_0000) begin
            e.sign_op = 3'd2; e.imm_used = 1'b1;
        end else if ((w & 32'hFE00_0000) == 32'hB400_0000) begin
            e.sign_op = 3'd3; e.imm_used = 1'b1;
        end else if (m11 == 32'hF840_0000 || m11 == 32'hF800_0000) begin
            e.sign_op = 3'd1; e.imm_used = 1'b1;
        end else if ((w & 32'hFFC0_0000) == 32'h9100_0000 ||
                     (w & 32'hFFC0_0000) == 32'hD100_0000) begin
            e.sign_op = 3'd0; e.imm_used = 1'b1;
        end else if ((w & 32'hFF80_0000) == 32'hD280_0000) begin
            e.sign_op = 3'd4; e.imm_used = 1'b1;
        end else if (m11 == 32'h8B00_0000 || m11 == 32'hCB00_0000 ||
                     m11 == 32'h8A00_0000 || m11 == 32'hAA00_0000) begin
            e.sign_op = 3'd0;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    // One clock: drive inputs, check the current cycle, advance the model.
    task automatic step(input logic v, input logic [31:0] w, input logic [63:0] pc,
                        input logic ordy, input logic fl);
        exp_t e;
        exp_t h;
        logic push;
        logic pop;
        int   cnt;
        InValid  = v;
        InInstr  = w;
        InPC     = pc;
        OutReady = ordy;
        Flush    = fl;
        cnt = sb.size();
        chk("in_ready", 64'(InReady), 64'(cnt != 2));
        chk("out_valid", 64'(OutValid), 64'(cnt != 0));
        chk("ill_count", 64'(IllegalCount), 64'(m_ill));
        if (cnt != 0) begin
            h = sb[0];
            chk("imm26", 64'(OutImm26), 64'(h.imm26));
            chk("sign_op", 64'(OutSignOp), 64'(h.sign_op));
            chk("imm_used", 64'(OutImmUsed), 64'(h.imm_used));
            chk("illegal", 64'(OutIllegal), 64'(h.illegal));
            chk("pc", OutPC, h.pc);
        end
        push = v && (cnt != 2) && !fl;
        pop  = (cnt != 0) && ordy && !fl;
        e = ref_decode(w, pc);
        @(posedge Clk);
        #1;
        if (push && e.illegal && m_ill != 8'hFF) m_ill = m_ill + 8'd1;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back(e);
        end
        last_push = push;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++)
            step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("drained", 64'(OutValid), 64'd0);
    endtask

    task automatic do_reset();
        ResetL   = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Flush    = 1'b0;
        InInstr  = 32'h0;
        InPC     = 64'h0;
        @(posedge Clk);
        #1;
        ResetL = 1'b1;
        sb.delete();
        m_ill = '0;
        chk("rst_out_valid", 64'(OutValid), 64'd0);
        chk("rst_in_ready", 64'(InReady), 64'd1);
        chk("rst_ill_count", 64'(IllegalCount), 64'd0);
        chk("rst_imm26", 64'(OutImm26), 64'd0);
        chk("rst_sign_op", 64'(OutSignOp), 64'd0);
        chk("rst_imm_used", 64'(OutImmUsed), 64'd0);
        chk("rst_illegal", 64'(OutIllegal), 64'd0);
        chk("rst_pc", OutPC, 64'd0);
    endtask

    logic [31:0] pool [12];
    logic [31:0] dec_words [5];

    initial begin
        logic        pv;
        logic [31:0] pw;
        logic [63:0] ppc;
        logic        fl;
        n_checks  = 0;
        n_errors  = 0;
        m_ill     = '0;
        last_push = 1'b0;
        dec_words[0] = 32'h9100_0421;
        dec_words[1] = 32'hF840_0000;
        dec_words[2] = 32'h1400_0010;
        dec_words[3] = 32'hB400_0040;
        dec_words[4] = 32'hD2A0_0020;
        pool[0]  = 32'h1400_0000; pool[1]  = 32'hB500_0000;
        pool[2]  = 32'hF800_0000; pool[3]  = 32'hD100_0000;
        pool[4]  = 32'hD280_0000; pool[5]  = 32'hCB00_0000;
        pool[6]  = 32'h8A00_0000; pool[7]  = 32'hAA00_0000;
        pool[8]  = 32'hFFFF_FFFF; pool[9]  = 32'hF860_0000;
        pool[10] = 32'hD200_0000; pool[11] = 32'h9140_0000;

        do_reset();

        // Decode sequence with the consumer always ready.
        for (int i = 0; i < 5; i++)
            step(1'b1, dec_words[i], 64'h1000 + 64'(i * 4), 1'b1, 1'b0);
        drain();

        // R-type then an illegal word.
        step(1'b1, 32'h8B02_0020, 64'h2000, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0000, 64'h2004, 1'b1, 1'b0);
        chk("ill_after_zero", 64'(IllegalCount), 64'd1);
        drain();

        // Backpressure: third word held until space frees up.
        step(1'b1, 32'h9100_0001, 64'h3000, 1'b0, 1'b0);
        step(1'b1, 32'h9100_0002, 64'h3004, 1'b0, 1'b0);
        step(1'b1, 32'h9100_0003, 64'h3008, 1'b0, 1'b0);
        chk("bp_held", 64'(last_push), 64'd0);
        step(1'b1, 32'h9100_0003, 64'h3008, 1'b1, 1'b0);
        step(1'b1, 32'h9100_0003, 64'h3008, 1'b1, 1'b0);
        drain();

        // Concurrent push and pop at count 1.
        step(1'b1, 32'hD100_0100, 64'h4000, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            step(1'b1, 32'hD100_0100 + 32'(i), 64'h4000 + 64'(i * 4), 1'b1, 1'b0);
        drain();

        // Flush with two entries queued and an illegal word offered.
        step(1'b1, 32'h1400_0001, 64'h5000, 1'b0, 1'b0);
        step(1'b1, 32'h1400_0002, 64'h5004, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0000, 64'h5008, 1'b1, 1'b1);
        chk("flush_out_valid", 64'(OutValid), 64'd0);
        chk("flush_in_ready", 64'(InReady), 64'd1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Random mix, holding an offered word until it is taken.
        pv = 1'b0; pw = '0; ppc = '0;
        for (int i = 0; i < 60; i++) begin
            if (!pv) begin
                pv  = ($urandom_range(0, 3) != 0);
                pw  = pool[$urandom_range(0, 11)] | ($urandom & 32'h001F_FFFF);
                ppc = {32'h0, $urandom};
            end
            fl = ($urandom_range(0, 9) == 0);
            step(pv, pw, ppc, 1'($urandom_range(0, 1)), fl);
            if (last_push || fl) pv = 1'b0;
        end
        drain();

        // Saturation of the illegal counter.
        for (int i = 0; i < 300; i++)
            step(1'b1, 32'hFFFF_0000 | 32'(i), 64'h6000 + 64'(i), 1'b1, 1'b0);
        drain();
        chk("ill_saturated", 64'(IllegalCount), 64'hFF);

        // Reset with one entry queued.
        step(1'b1, 32'hB400_0080, 64'h7000, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(OutValid), 64'd1);
        do_reset();
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
